// File: rtl/gs_render_pkg.sv
// gs_render_pkg
//   Shared definitions for the Gaussian-splat render pipeline.
//   Holds the default fixed-point format and the alpha/transmittance thresholds.
//   Also holds the state encoding used by the front-to-back alpha compositor.
//   There are no ports; modules pull this in with import gs_render_pkg::*.
package gs_render_pkg;

  // Fractional bits of exp(power), opacity and alpha.
  localparam int FRAC_BITS_DEF = 8;

  // Alpha is clamped to 0.99 so that T never collapses to exactly zero in one step.
  localparam int ALPHA_MAX_DEF = 253;

  // Contributions below roughly 1/255 are invisible and are skipped entirely.
  localparam int ALPHA_MIN_DEF = 1;

  // Transmittance below roughly 1e-4 (Q0.16) ends the pixel.
  localparam int T_MIN_DEF     = 7;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUTPUT
  } blend_state_t;

endpackage

// File: rtl/alpha_calc.sv
// alpha_calc
//   Combinational alpha computation for one Gaussian contribution.
//   alpha = min((opacity * exp) >> FRAC_BITS, ALPHA_MAX), using the full double-width product.
//   skip is raised when alpha falls below ALPHA_MIN.
// Ports
//   exp_in      in   DATA_WIDTH  exp(power) from the exp stage, Q.FRAC_BITS
//   opacity_in  in   DATA_WIDTH  Gaussian opacity, Q.FRAC_BITS
//   alpha       out  DATA_WIDTH  clamped alpha, Q.FRAC_BITS
//   skip        out  1           contribution too faint to matter
module alpha_calc
  import gs_render_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = FRAC_BITS_DEF,
  parameter int ALPHA_MAX  = ALPHA_MAX_DEF,
  parameter int ALPHA_MIN  = ALPHA_MIN_DEF
) (
  input  logic [DATA_WIDTH-1:0] exp_in,
  input  logic [DATA_WIDTH-1:0] opacity_in,
  output logic [DATA_WIDTH-1:0] alpha,
  output logic                  skip
);

  logic [2*DATA_WIDTH-1:0] product;
  logic [2*DATA_WIDTH-1:0] shifted;

  // Full-width product: exp_in above 1.0 is legal, so the raw product can greatly
  // exceed the alpha range and must not wrap before the clamp sees it.
  always_comb begin
    product = {{DATA_WIDTH{1'b0}}, opacity_in} * {{DATA_WIDTH{1'b0}}, exp_in};
    shifted = product >> FRAC_BITS;
    if (shifted > (2*DATA_WIDTH)'(ALPHA_MAX)) begin
      alpha = DATA_WIDTH'(ALPHA_MAX);
    end else begin
      alpha = shifted[DATA_WIDTH-1:0];
    end
    skip = (alpha < DATA_WIDTH'(ALPHA_MIN));
  end

endmodule

// File: rtl/alpha_blend_accum.sv
// alpha_blend_accum
//   Per-pixel front-to-back alpha compositor, fed by the fixed-point exp stage.
//   For each accepted Gaussian it derives alpha, weights the colour by the current
//   transmittance T, and retires T. When T would drop below T_MIN the pixel
//   terminates early and the rest of its list is drained unaccumulated.
//   One final colour/T/count result is emitted per pixel list.
// Ports
//   clk          in   1              clock
//   rst_n        in   1              synchronous active-low reset
//   pixel_start  in   1              open a new pixel (only honoured in IDLE)
//   in_valid     in   1              contribution valid
//   in_ready     out  1              contribution accepted when in_valid & in_ready
//   exp_in       in   DATA_WIDTH     exp(power)
//   opacity_in   in   DATA_WIDTH     opacity, Q.FRAC_BITS
//   color_in     in   3*COLOR_WIDTH  {R,G,B}, R in MSBs
//   last_in      in   1              last Gaussian of this pixel's list
//   out_valid    out  1              final pixel result valid
//   out_ready    in   1              downstream accepts result
//   out_color    out  3*COLOR_WIDTH  composited {R,G,B}
//   out_trans    out  T_FRAC+1       final transmittance
//   out_count    out  CNT_WIDTH      number of contributing Gaussians
module alpha_blend_accum
  import gs_render_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int COLOR_WIDTH = 8,
  parameter int T_FRAC      = 16,
  parameter int ALPHA_MAX   = ALPHA_MAX_DEF,
  parameter int ALPHA_MIN   = ALPHA_MIN_DEF,
  parameter int T_MIN       = T_MIN_DEF,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pixel_start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    exp_in,
  input  logic [DATA_WIDTH-1:0]    opacity_in,
  input  logic [3*COLOR_WIDTH-1:0] color_in,
  input  logic                     last_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3*COLOR_WIDTH-1:0] out_color,
  output logic [T_FRAC:0]          out_trans,
  output logic [CNT_WIDTH-1:0]     out_count
);

  localparam int TW = T_FRAC + 1;
  localparam int AW = COLOR_WIDTH + T_FRAC + 1;

  blend_state_t state, state_nxt;

  logic [TW-1:0]          t_reg, t_nxt;
  logic [2:0][AW-1:0]     acc, acc_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic [3*COLOR_WIDTH-1:0] color_sat;

  logic [DATA_WIDTH-1:0]  alpha;
  logic                   skip;
  logic                   accept;
  logic                   terminate;
  logic                   load_out;
  logic [TW-1:0]          w;
  logic [TW-1:0]          t_sub;

  alpha_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ALPHA_MAX  (ALPHA_MAX),
    .ALPHA_MIN  (ALPHA_MIN)
  ) u_alpha_calc (
    .exp_in     (exp_in),
    .opacity_in (opacity_in),
    .alpha      (alpha),
    .skip       (skip)
  );

  assign in_ready  = (state == ACCUM) || (state == DRAIN);
  assign out_valid = (state == OUTPUT);
  assign accept    = in_valid && in_ready;

  // Weight and candidate transmittance. alpha is clamped below 1.0, so w < T and
  // the subtraction never underflows; the truncating cast only drops zero bits.
  always_comb begin
    w         = TW'(({{DATA_WIDTH{1'b0}}, t_reg} * {{TW{1'b0}}, alpha}) >> FRAC_BITS);
    t_sub     = t_reg - w;
    terminate = (t_sub < TW'(T_MIN));
  end

  // Next-state and next-accumulator logic. Everything defaults to "hold"; a pixel
  // that terminates keeps the T/acc/cnt from before the offending contribution.
  // The result registers are loaded from the *next* values on entry to OUTPUT so
  // that a non-terminating last contribution is already folded in.
  always_comb begin
    state_nxt = state;
    t_nxt     = t_reg;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (pixel_start) begin
          state_nxt = ACCUM;
          t_nxt     = TW'(1) << T_FRAC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (!skip && terminate) begin
            state_nxt = last_in ? OUTPUT : DRAIN;
          end else begin
            if (!skip) begin
              for (int c = 0; c < 3; c++) begin
                acc_nxt[c] = acc[c] + (AW'(color_in[c*COLOR_WIDTH +: COLOR_WIDTH]) * AW'(w));
              end
              t_nxt = t_sub;
              if (cnt != {CNT_WIDTH{1'b1}}) begin
                cnt_nxt = cnt + 1'b1;
              end
            end
            if (last_in) begin
              state_nxt = OUTPUT;
            end
          end
        end
      end
      DRAIN: begin
        if (accept && last_in) begin
          state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    load_out = (state_nxt == OUTPUT) && (state != OUTPUT);
  end

  // Normalise each accumulated channel back to colour range, saturating at full scale.
  always_comb begin
    color_sat = '0;
    for (int c = 0; c < 3; c++) begin
      if ((acc_nxt[c] >> T_FRAC) > AW'({COLOR_WIDTH{1'b1}})) begin
        color_sat[c*COLOR_WIDTH +: COLOR_WIDTH] = {COLOR_WIDTH{1'b1}};
      end else begin
        color_sat[c*COLOR_WIDTH +: COLOR_WIDTH] = acc_nxt[c][T_FRAC +: COLOR_WIDTH];
      end
    end
  end

  // State, working registers and result registers. Reset aborts any pixel in
  // flight and clears the result so nothing stale is ever presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      t_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_color <= '0;
      out_trans <= '0;
      out_count <= '0;
    end else begin
      state <= state_nxt;
      t_reg <= t_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      if (load_out) begin
        out_color <= color_sat;
        out_trans <= t_nxt;
        out_count <= cnt_nxt;
      end
    end
  end

endmodule
